ah_stream_demux: RTL and testbench

- Parametrised, registered successor to the 8x8 one-hot combinational demultiplexer.
- Routes a valid/ready input stream to one of NUM_CH output channels, or multicasts it to several.
- Each channel has a one-entry output register with independent backpressure.
- Sits between a single producer and several consumer pipelines in the datapath.

---
 rtl/ah_demux_pkg.sv | 18 +
 rtl/ah_demux_slot.sv | 47 ++++
 rtl/ah_stream_demux.sv | 82 ++++++++
 tb/tb_ah_stream_demux.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_demux_pkg.sv
// Shared definitions for the stream demultiplexer: legal channel range and
// the binary-index to one-hot decoder used when the select is an index.
package ah_demux_pkg;

    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 32;

    // Indices at or beyond n (or beyond the widest legal demux) decode to an empty mask.
    function automatic logic [NUM_CH_MAX-1:0] onehot_of(input int index, input int n);
        logic [NUM_CH_MAX-1:0] mask;
        mask = '0;
        if (index >= 0 && index < n && index < NUM_CH_MAX) begin
            mask[index[4:0]] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/ah_demux_slot.sv
// One-entry output register for a single demux channel. A load always wins
// over a drain, so a slot can accept a new word in the cycle its old one leaves.
module ah_demux_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  free_o
);

    logic                  valid_q;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // A slot being drained this cycle may be refilled in the same cycle.
    assign free_o  = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ah_stream_demux.sv
// Registered valid/ready demultiplexer: routes (or multicasts) one input stream
// into NUM_CH independently back-pressured one-entry output slots.
module ah_stream_demux
    import ah_demux_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_CH     = 8,
    parameter int  SEL_ONEHOT = 1,
    parameter int  CNT_W      = 16,
    localparam int SEL_W      = (SEL_ONEHOT != 0) ? NUM_CH : $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]             in_select,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]             drop_count,
    input  logic                         clr_drop
);

    logic [NUM_CH-1:0] target;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              accept;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W-1:0]  drop_d;

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("ah_stream_demux: NUM_CH outside the supported range");
    end

    if (SEL_ONEHOT != 0) begin : g_sel_mask
        assign target = in_select;
    end else begin : g_sel_index
        assign target = NUM_CH'(onehot_of(int'(in_select), NUM_CH));
    end

    // Multicast is all-or-nothing: every targeted slot must be free before any loads.
    assign in_ready = &(~target | free);
    assign accept   = in_valid & in_ready;
    assign load     = {NUM_CH{accept}} & target;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        ah_demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[i]),
            .data_i (in_data),
            .ready_i(out_ready[i]),
            .valid_o(out_valid[i]),
            .data_o (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .free_o (free[i])
        );
    end

    // Words accepted with an empty target are consumed and counted; clear beats increment.
    always_comb begin
        drop_d = drop_q;
        if (clr_drop) begin
            drop_d = '0;
        end else if (accept && (target == '0) && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_ah_stream_demux.sv
// Self-checking bench: instance A is a 6-channel binary-select demux with a 2-bit
// drop counter, instance B an 8-channel one-hot (multicast) demux with defaults.
module tb_ah_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        aInValid, aInReady, aClr;
    logic [7:0]  aInData;
    logic [2:0]  aInSelect;
    logic [5:0]  aOutValid, aOutReady;
    logic [47:0] aOutData;
    logic [1:0]  aDrop;

    logic        bInValid, bInReady, bClr;
    logic [7:0]  bInData;
    logic [7:0]  bInSelect;
    logic [7:0]  bOutValid, bOutReady;
    logic [63:0] bOutData;
    logic [15:0] bDrop;

    int checks = 0;
    int failures = 0;

    ah_stream_demux #(
        .DATA_WIDTH(8), .NUM_CH(6), .SEL_ONEHOT(0), .CNT_W(2)
    ) dutA (
        .clk(clk), .rst(rst), .in_valid(aInValid), .in_ready(aInReady),
        .in_data(aInData), .in_select(aInSelect), .out_valid(aOutValid),
        .out_ready(aOutReady), .out_data(aOutData), .drop_count(aDrop),
        .clr_drop(aClr)
    );

    ah_stream_demux #(
        .DATA_WIDTH(8), .NUM_CH(8), .SEL_ONEHOT(1), .CNT_W(16)
    ) dutB (
        .clk(clk), .rst(rst), .in_valid(bInValid), .in_ready(bInReady),
        .in_data(bInData), .in_select(bInSelect), .out_valid(bOutValid),
        .out_ready(bOutReady), .out_data(bOutData), .drop_count(bDrop),
        .clr_drop(bClr)
    );

    // Reference model: per-instance slot contents and drop count (inst 0 = A, 1 = B).
    bit        mValid [2][8];
    bit [7:0]  mData  [2][8];
    int        mDrop  [2];

    function automatic int chCount(input int inst);
        return (inst == 0) ? 6 : 8;
    endfunction

    function automatic int dropMax(input int inst);
        return (inst == 0) ? 3 : 65535;
    endfunction

    function automatic logic [7:0] targetMask(input int inst, input int sel);
        if (inst == 1) return 8'(sel);
        if (sel < 6) return 8'(1 << sel);
        return 8'h00;
    endfunction

    function automatic logic expReady(input int inst, input int sel, input logic [7:0] ordy);
        logic [7:0] t;
        t = targetMask(inst, sel);
        for (int i = 0; i < chCount(inst); i++) begin
            if (t[i] && mValid[inst][i] && !ordy[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelStep(input int inst, input logic v, input logic [7:0] d,
                             input int sel, input logic [7:0] ordy, input logic clr);
        logic [7:0] t;
        logic       acc;
        t   = targetMask(inst, sel);
        acc = v && expReady(inst, sel, ordy);
        for (int i = 0; i < chCount(inst); i++) begin
            if (acc && t[i]) begin
                mValid[inst][i] = 1'b1;
                mData[inst][i]  = d;
            end else if (mValid[inst][i] && ordy[i]) begin
                mValid[inst][i] = 1'b0;
            end
        end
        if (clr) mDrop[inst] = 0;
        else if (acc && t == 8'h00 && mDrop[inst] < dropMax(inst)) mDrop[inst] = mDrop[inst] + 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) begin
                    mValid[k][i] = 1'b0;
                    mData[k][i]  = 8'h00;
                end
                mDrop[k] = 0;
            end
        end else begin
            modelStep(0, aInValid, aInData, int'(aInSelect), 8'(aOutReady), aClr);
            modelStep(1, bInValid, bInData, int'(bInSelect), bOutReady, bClr);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every falling edge: all outputs of both instances against the model.
    always @(negedge clk) begin
        logic [7:0]  ev;
        logic [63:0] ed;
        for (int k = 0; k < 2; k++) begin
            ev = '0;
            ed = '0;
            for (int i = 0; i < chCount(k); i++) begin
                ev[i]        = mValid[k][i];
                ed[i*8 +: 8] = mData[k][i];
            end
            if (k == 0) begin
                checkOutput("A.out_valid", 64'(aOutValid), 64'(ev));
                checkOutput("A.out_data", 64'(aOutData), ed);
                checkOutput("A.drop_count", 64'(aDrop), 64'(mDrop[0]));
                checkOutput("A.in_ready", 64'(aInReady), 64'(expReady(0, int'(aInSelect), 8'(aOutReady))));
            end else begin
                checkOutput("B.out_valid", 64'(bOutValid), 64'(ev));
                checkOutput("B.out_data", bOutData, ed);
                checkOutput("B.drop_count", 64'(bDrop), 64'(mDrop[1]));
                checkOutput("B.in_ready", 64'(bInReady), 64'(expReady(1, int'(bInSelect), bOutReady)));
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        aInValid = 0; aClr = 0; aInData = 0; aInSelect = 0; aOutReady = '1;
        bInValid = 0; bClr = 0; bInData = 0; bInSelect = 8'hFF; bOutReady = 8'h00;
        applyStimulus();
        applyStimulus();
        checkOutput("reset A.out_valid", 64'(aOutValid), 64'h0);
        checkOutput("reset B.out_valid", 64'(bOutValid), 64'h0);
        checkOutput("reset B.out_data", bOutData, 64'h0);
        checkOutput("reset A.drop", 64'(aDrop), 64'h0);
        checkOutput("reset B.in_ready", 64'(bInReady), 64'h1);
        rst = 1'b0;
        bOutReady = 8'hFF;
        bInSelect = 8'h00;
        applyStimulus();

        // Binary unicast to channel 3.
        aInSelect = 3; aInData = 8'hA5; aInValid = 1;
        applyStimulus();
        aInValid = 0;
        checkOutput("unicast valid", 64'(aOutValid), 64'h08);
        checkOutput("unicast data", 64'(aOutData[3*8 +: 8]), 64'hA5);
        applyStimulus();
        checkOutput("unicast drained", 64'(aOutValid), 64'h00);

        // Back-to-back streaming on channel 1, one word per cycle.
        for (int k = 0; k < 16; k++) begin
            aInSelect = 1; aInData = 8'(k); aInValid = 1;
            #1 checkOutput("stream in_ready", 64'(aInReady), 64'h1);
            applyStimulus();
            checkOutput("stream valid", 64'(aOutValid), 64'h02);
            checkOutput("stream data", 64'(aOutData[1*8 +: 8]), 64'(k));
        end
        aInValid = 0;
        applyStimulus();
        checkOutput("stream end", 64'(aOutValid), 64'h00);

        // Illegal selects are dropped; 2-bit counter saturates; clear wins.
        aInSelect = 7; aInValid = 1;
        applyStimulus();
        aInValid = 0;
        checkOutput("drop sel7 count", 64'(aDrop), 64'h1);
        checkOutput("drop sel7 no output", 64'(aOutValid), 64'h0);
        aInSelect = 6; aInValid = 1;
        applyStimulus();
        checkOutput("drop sel6 count", 64'(aDrop), 64'h2);
        aInSelect = 7;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("drop saturate", 64'(aDrop), 64'h3);
        aClr = 1;
        applyStimulus();
        aClr = 0; aInValid = 0;
        checkOutput("clr beats drop", 64'(aDrop), 64'h0);

        // Multicast blocked by a busy channel 2, then released.
        bOutReady = 8'hFB; bInSelect = 8'h04; bInData = 8'h11; bInValid = 1;
        applyStimulus();
        bInSelect = 8'h05; bInData = 8'h77;
        #1 checkOutput("mcast blocked ready", 64'(bInReady), 64'h0);
        applyStimulus();
        checkOutput("mcast blocked valid", 64'(bOutValid), 64'h04);
        checkOutput("mcast ch0 not loaded", 64'(bOutData[0 +: 8]), 64'h00);
        checkOutput("mcast ch2 held", 64'(bOutData[2*8 +: 8]), 64'h11);
        bOutReady = 8'hFF;
        #1 checkOutput("mcast release ready", 64'(bInReady), 64'h1);
        applyStimulus();
        bInValid = 0;
        checkOutput("mcast valid", 64'(bOutValid), 64'h05);
        checkOutput("mcast ch0 data", 64'(bOutData[0 +: 8]), 64'h77);
        checkOutput("mcast ch2 data", 64'(bOutData[2*8 +: 8]), 64'h77);
        applyStimulus();
        checkOutput("mcast drained", 64'(bOutValid), 64'h00);

        // Backpressure hold on channel 4 for 10 cycles.
        bOutReady = 8'hEF; bInSelect = 8'h10; bInData = 8'h3C; bInValid = 1;
        applyStimulus();
        bInValid = 0;
        for (int j = 0; j < 10; j++) begin
            bInSelect = 8'(1 << (j % 8));
            #1;
            checkOutput("hold valid4", 64'(bOutValid[4]), 64'h1);
            checkOutput("hold data4", 64'(bOutData[4*8 +: 8]), 64'h3C);
            checkOutput("hold in_ready", 64'(bInReady), ((j % 8) == 4) ? 64'h0 : 64'h1);
            applyStimulus();
        end
        bOutReady = 8'hFF;
        applyStimulus();
        checkOutput("hold drained", 64'(bOutValid), 64'h00);

        // Empty one-hot select is a drop.
        bInSelect = 8'h00; bInValid = 1;
        applyStimulus();
        bInValid = 0;
        checkOutput("B empty drop", 64'(bDrop), 64'h1);
        checkOutput("B empty no output", 64'(bOutValid), 64'h00);

        // Asynchronous reset with three channels holding words.
        bOutReady = 8'h00; bInSelect = 8'h0B; bInData = 8'h5A; bInValid = 1;
        aInSelect = 7; aInValid = 1;
        applyStimulus();
        bInValid = 0; aInValid = 0;
        checkOutput("pre-reset valid", 64'(bOutValid), 64'h0B);
        checkOutput("pre-reset A drop", 64'(aDrop), 64'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset valid", 64'(bOutValid), 64'h00);
        checkOutput("async reset B drop", 64'(bDrop), 64'h0);
        checkOutput("async reset A drop", 64'(aDrop), 64'h0);
        checkOutput("async reset ready", 64'(bInReady), 64'h1);
        applyStimulus();
        rst = 1'b0;
        bOutReady = 8'hFF; bInSelect = 8'h40; bInData = 8'hC3; bInValid = 1;
        applyStimulus();
        bInValid = 0;
        checkOutput("post-reset valid", 64'(bOutValid), 64'h40);
        checkOutput("post-reset data", 64'(bOutData[6*8 +: 8]), 64'hC3);
        applyStimulus();
        checkOutput("post-reset drained", 64'(bOutValid), 64'h00);

        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
